audio_clkgen: RTL and testbench
===============================

Name: audio_clkgen

Overview:
- Sits directly downstream of the system clock/reset manager and consumes its 256*fs clock (12 MHz, fs = 46.875 kHz) and its synchronous reset.
- Sequences codec power-up: holds PDN low, waits for the wake time, then starts the frame clocks.
- Generates the TDM serial clocks (BICK, LRCK) for a 4-slot x 32-bit frame, plus frame/slot/bit timing strobes for the serial shifter stages.
- Every output is driven directly from a flop (glitch-free at the pins).

Parameters:
PDN_CYCLES, 1024, clk_256fs cycles PDN is held low after reset release; legal range 1..65535
WAKE_CYCLES, 4096, clk_256fs cycles between PDN release and frame-clock start; legal range 1..65535
W, 32, bits per TDM slot; fixed by frame geometry, SLOTS*W*2 must equal 256
SLOTS, 4, TDM slots per frame

Ports:
clk_256fs  input  1  system audio clock, 256*fs
rst  input  1  synchronous, active-high reset
pdn  output  1  codec power-down, active low
running  output  1  high while frame clocks run
bick  output  1  TDM bit clock, 128*fs
lrck  output  1  TDM frame sync
sample_strobe  output  1  one-cycle pulse in the last cycle of each frame
slot  output  $clog2(SLOTS)  current TDM slot index
bit_idx  output  $clog2(W)  current bit within slot; 0 = MSB

Behaviour:
- Clocking and reset:
  - Single clock domain, clk_256fs; rst is synchronous and active-high.
  - Reset values: pdn=0, running=0, bick=0, lrck=0, sample_strobe=0, slot=0, bit_idx=0.
  - Internal state: FSM state S_PDN, 16-bit timer = 0, 8-bit frame counter cnt = 0.
- FSM states:
  - S_PDN:
    - pdn=0; frame clocks idle (bick=0, lrck=0, running=0); timer counts.
    - When timer == PDN_CYCLES-1: go to S_WAKE, timer=0.
  - S_WAKE:
    - pdn=1; frame clocks still idle; timer counts.
    - When timer == WAKE_CYCLES-1: go to S_RUN, cnt=0.
  - S_RUN:
    - pdn=1, running=1; cnt increments every cycle, wrapping 255->0.
    - No exit except rst.
- PDN timing: cycle 0 is the first rising edge with rst low. pdn reads 1 from cycle PDN_CYCLES.
- RUN timing:
  - running reads 1 and cnt reads 0 from cycle PDN_CYCLES+WAKE_CYCLES.
  - Registered outputs are computed from next-cnt so that they match cnt in the same cycle.
- Output values in S_RUN, for the cycle with cnt = k:
  - bick = k[0], so BICK period is 2 clocks and low in the first half of each bit. Data launches on the falling edge; the codec samples on the rising edge.
  - lrck = 1 for k in 0..127, 0 for k in 128..255 (50% duty). The rising edge marks frame start.
  - bit_idx = k[5:1], slot = k[7:6].
  - sample_strobe = 1 only when k == 255.
- First strobe: the first sample_strobe occurs 255 cycles after running rises.
- Outside S_RUN: bick, lrck, slot, bit_idx and sample_strobe are held at 0.
- Reset mid-operation: rst high in any state returns all outputs to their reset values on that edge. pdn drops to 0 immediately and the full PDN/WAKE sequence repeats.
- Simultaneous events: rst has priority over all state transitions and counter wrap.

Optional Feature:
- Macro: AUDIO_CLKGEN_LRCK_PULSE_EN.
- Defined: lrck is a one-BICK pulse, high only for k in 0..1 (codec TDM pulse mode). All other outputs unchanged.
- Undefined: 50% duty LRCK as specified above.

Test Plan:
- PDN_CYCLES=4, WAKE_CYCLES=8, rst high 3 cycles then low -> pdn=0 for cycles 0..3 and 1 from cycle 4; running=0 through cycle 11 and 1 at cycle 12; bick=lrck=0 throughout cycles 0..11.
- Run 3 full frames after running rises -> each frame has exactly 128 bick rising edges and 1 lrck rising edge at cnt=0; lrck high for exactly 128 cycles; sample_strobe high exactly at cnt=255, 256 cycles apart.
- Check slot/bit_idx across one frame -> slot steps 0,1,2,3 every 64 cycles; bit_idx counts 0..31 within each slot, changing on cnt even; values at cnt=65 are slot=1, bit_idx=0.
- Assert rst for 1 cycle at cnt=100 in S_RUN -> next cycle pdn=0, running=0, bick=0, lrck=0, sample_strobe=0; pdn re-rises exactly PDN_CYCLES cycles after rst deasserts.
- Build with AUDIO_CLKGEN_LRCK_PULSE_EN, run 2 frames -> lrck high only at cnt 0 and 1 of each frame; bick/strobe timing identical to default build.
- PDN_CYCLES=1, WAKE_CYCLES=1 boundary -> pdn=1 at cycle 1; running=1 with cnt=0 at cycle 2.

Source files
------------

// File: rtl/audio_clkgen.sv
// audio_clkgen: codec power-up sequencer and TDM BICK/LRCK generator.
// Optional AUDIO_CLKGEN_LRCK_PULSE_EN selects one-BICK LRCK pulse mode.
module audio_clkgen #(
  parameter int PDN_CYCLES  = 1024,
  parameter int WAKE_CYCLES = 4096,
  parameter int W           = 32,
  parameter int SLOTS       = 4
) (
  input  logic                     clk_256fs,
  input  logic                     rst,
  output logic                     pdn,
  output logic                     running,
  output logic                     bick,
  output logic                     lrck,
  output logic                     sample_strobe,
  output logic [$clog2(SLOTS)-1:0] slot,
  output logic [$clog2(W)-1:0]     bit_idx
);

  localparam int SW = $clog2(SLOTS);
  localparam int BW = $clog2(W);

  localparam logic [15:0] PDN_LAST =
    16'(PDN_CYCLES - 1);
  localparam logic [15:0] WAKE_LAST =
    16'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PDN,
    S_WAKE,
    S_RUN
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [15:0] timer;
  logic [15:0] timer_n;
  logic [7:0]  cnt;
  logic [7:0]  cnt_n;

  logic          pdn_n;
  logic          run_n;
  logic          bick_n;
  logic          lrck_n;
  logic          strobe_n;
  logic [SW-1:0] slot_n;
  logic [BW-1:0] bit_n;

  // Next state, timers and pin values derived from next cnt so
  // that registered outputs line up with cnt in the same cycle.
  always_comb begin
    state_n = state;
    timer_n = timer + 16'd1;
    cnt_n   = cnt;
    unique case (state)
      S_PDN: begin
        if (timer == PDN_LAST) begin
          state_n = S_WAKE;
          timer_n = '0;
        end
      end
      S_WAKE: begin
        if (timer == WAKE_LAST) begin
          state_n = S_RUN;
          timer_n = '0;
          cnt_n   = '0;
        end
      end
      S_RUN: begin
        timer_n = timer;
        cnt_n   = cnt + 8'd1;
      end
      default: begin
        state_n = S_PDN;
        timer_n = '0;
      end
    endcase

    pdn_n    = (state_n != S_PDN);
    run_n    = (state_n == S_RUN);
    bick_n   = run_n & cnt_n[0];
`ifdef AUDIO_CLKGEN_LRCK_PULSE_EN
    lrck_n   = run_n & (cnt_n[7:1] == 7'd0);
`else
    lrck_n   = run_n & ~cnt_n[7];
`endif
    strobe_n = run_n & (cnt_n == 8'hFF);
    slot_n   = run_n ? cnt_n[BW+1 +: SW] : '0;
    bit_n    = run_n ? cnt_n[1 +: BW] : '0;
  end

  // State, counters and every output pin come straight off flops.
  always_ff @(posedge clk_256fs) begin
    if (rst) begin
      state         <= S_PDN;
      timer         <= '0;
      cnt           <= '0;
      pdn           <= 1'b0;
      running       <= 1'b0;
      bick          <= 1'b0;
      lrck          <= 1'b0;
      sample_strobe <= 1'b0;
      slot          <= '0;
      bit_idx       <= '0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      cnt           <= cnt_n;
      pdn           <= pdn_n;
      running       <= run_n;
      bick          <= bick_n;
      lrck          <= lrck_n;
      sample_strobe <= strobe_n;
      slot          <= slot_n;
      bit_idx       <= bit_n;
    end
  end

endmodule

// File: tb/tb_audio_clkgen.sv
// tb_audio_clkgen: directed checks of power-up timing, TDM frame
// clocks, mid-run reset and the 1/1 timer boundary.
module tb_audio_clkgen;

  logic       clk = 1'b0;
  logic       rst;

  logic       pdn0, run0, bick0, lrck0, stb0;
  logic [1:0] slot0;
  logic [4:0] bit0;

  logic       pdn1, run1, bick1, lrck1, stb1;
  logic [1:0] slot1;
  logic [4:0] bit1;

  int n_cmp = 0;
  int n_err = 0;

  audio_clkgen #(
    .PDN_CYCLES (4),
    .WAKE_CYCLES(8)
  ) u0 (
    .clk_256fs    (clk),
    .rst          (rst),
    .pdn          (pdn0),
    .running      (run0),
    .bick         (bick0),
    .lrck         (lrck0),
    .sample_strobe(stb0),
    .slot         (slot0),
    .bit_idx      (bit0)
  );

  audio_clkgen #(
    .PDN_CYCLES (1),
    .WAKE_CYCLES(1)
  ) u1 (
    .clk_256fs    (clk),
    .rst          (rst),
    .pdn          (pdn1),
    .running      (run1),
    .bick         (bick1),
    .lrck         (lrck1),
    .sample_strobe(stb1),
    .slot         (slot1),
    .bit_idx      (bit1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic exp_lrck(input logic [7:0] k);
`ifdef AUDIO_CLKGEN_LRCK_PULSE_EN
    return (k[7:1] == 7'd0);
`else
    return ~k[7];
`endif
  endfunction

  function automatic int exp_lrck_hi();
`ifdef AUDIO_CLKGEN_LRCK_PULSE_EN
    return 2;
`else
    return 128;
`endif
  endfunction

  task automatic chk_reset0(input string tag);
    chk({tag, "_pdn"},  32'(pdn0),  0);
    chk({tag, "_run"},  32'(run0),  0);
    chk({tag, "_bick"}, 32'(bick0), 0);
    chk({tag, "_lrck"}, 32'(lrck0), 0);
    chk({tag, "_stb"},  32'(stb0),  0);
    chk({tag, "_slot"}, 32'(slot0), 0);
    chk({tag, "_bit"},  32'(bit0),  0);
  endtask

  initial begin
    logic [7:0] k;
    logic       pb, pl;
    int         br, lr, lh, last_stb;

    // Reset for three edges; value seen before the next edge is cycle 0.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset0("rst0");
    chk("rst0_u1_pdn", 32'(pdn1), 0);
    chk("rst0_u1_run", 32'(run1), 0);

    // Power-up sequence, cycles 1..12.
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("pu_pdn", 32'(pdn0), 32'(c >= 4));
      chk("pu_run", 32'(run0), 32'(c >= 12));
      chk("pu_bick", 32'(bick0), 0);
      if (c <= 11)
        chk("pu_lrck_idle", 32'(lrck0), 0);
      if (c <= 2) begin
        chk("b1_pdn", 32'(pdn1), 32'(c >= 1));
        chk("b1_run", 32'(run1), 32'(c >= 2));
      end
      if (c == 2) begin
        chk("b1_bick", 32'(bick1), 0);
        chk("b1_lrck", 32'(lrck1), 32'(exp_lrck(8'd0)));
        chk("b1_slot", 32'(slot1), 0);
        chk("b1_bit",  32'(bit1),  0);
        chk("b1_stb",  32'(stb1),  0);
      end
    end

    // Three frames from cnt=0.
    pb = 1'b0;
    pl = 1'b0;
    br = 0;
    lr = 0;
    lh = 0;
    last_stb = -1;
    for (int i = 0; i < 768; i++) begin
      k = i[7:0];
      chk("run_pdn",  32'(pdn0),  1);
      chk("run_run",  32'(run0),  1);
      chk("run_bick", 32'(bick0), 32'(k[0]));
      chk("run_lrck", 32'(lrck0), 32'(exp_lrck(k)));
      chk("run_stb",  32'(stb0),  32'(k == 8'hFF));
      chk("run_slot", 32'(slot0), 32'(k[7:6]));
      chk("run_bit",  32'(bit0),  32'(k[5:1]));
      if (bick0 && !pb) br++;
      if (lrck0 && !pl) begin
        lr++;
        chk("lrck_rise_cnt", 32'(k), 0);
      end
      if (lrck0) lh++;
      if (stb0) begin
        if (last_stb < 0)
          chk("first_stb", i, 255);
        else
          chk("stb_gap", i - last_stb, 256);
        last_stb = i;
      end
      pb = bick0;
      pl = lrck0;
      if (k == 8'hFF) begin
        chk("frame_bick_rises", br, 128);
        chk("frame_lrck_rises", lr, 1);
        chk("frame_lrck_high", lh, exp_lrck_hi());
        br = 0;
        lr = 0;
        lh = 0;
      end
      step();
    end
    chk("stb_last", last_stb, 767);

    // Advance to cnt=100 then pulse reset for one edge.
    repeat (100) step();
    chk("c100_slot", 32'(slot0), 1);
    chk("c100_bit",  32'(bit0),  18);
    chk("c100_bick", 32'(bick0), 0);
    rst = 1'b1;
    step();
    chk_reset0("mid_rst");
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("re_pdn", 32'(pdn0), 32'(c >= 4));
      chk("re_run", 32'(run0), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
